// File: rtl/bus_responder.sv
// Wait-state bus slave: a 16-bit RAM plus four I/O registers behind an
// IDLE/WAIT/ACK handshake that pulses active-low readyb for one cycle.
module bus_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] bus_address,
  input  logic [3:0]  bus_status,
  input  logic        bus_upper_byte_enable,
  input  logic [15:0] bus_wdata,
  output logic [15:0] bus_rdata,
  output logic        readyb
);

  localparam logic [3:0] CMD_MEM_RD = 4'b1001;
  localparam logic [3:0] CMD_MEM_WR = 4'b1010;
  localparam logic [3:0] CMD_IO_RD  = 4'b0101;
  localparam logic [3:0] CMD_IO_WR  = 4'b0110;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] addr_q, addr_d;
  logic [3:0]  cmd_q, cmd_d;
  logic        ube_q, ube_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        readyb_q, readyb_d;
  logic [15:0] io_q [4];
  logic [15:0] mem_q [0:(1 << ADDR_WIDTH) - 1];

  // The transaction being decoded: live bus in IDLE (zero-wait reads must
  // resolve at the capture edge), captured copy afterwards.
  logic [19:0]           txn_addr;
  logic [3:0]            txn_cmd;
  logic                  txn_ube;
  logic                  txn_lo_en, txn_hi_en, txn_is_read;
  logic                  io_hit;
  logic [1:0]            io_sel;
  logic [ADDR_WIDTH-1:0] mem_idx;
  logic [15:0]           rd_word;
  logic                  cmd_valid;
  logic                  mem_we, io_we;
  logic                  unused_addr_hi;

  assign txn_addr  = (state_q == S_IDLE) ? bus_address : addr_q;
  assign txn_cmd   = (state_q == S_IDLE) ? bus_status : cmd_q;
  assign txn_ube   = (state_q == S_IDLE) ? bus_upper_byte_enable : ube_q;
  assign txn_lo_en = ~txn_addr[0];
  assign txn_hi_en = txn_ube;
  assign txn_is_read = (txn_cmd == CMD_MEM_RD) || (txn_cmd == CMD_IO_RD);
  assign io_hit    = (txn_addr[15:3] == 13'd0);
  assign io_sel    = txn_addr[2:1];
  assign mem_idx   = txn_addr[ADDR_WIDTH:1];
  assign unused_addr_hi = ^txn_addr[19:16];

  assign cmd_valid = (bus_status == CMD_MEM_RD) || (bus_status == CMD_MEM_WR) ||
                     (bus_status == CMD_IO_RD)  || (bus_status == CMD_IO_WR);

  // A0=1 with ube=0 enables neither lane, which is exactly the illegal code.
  always_comb begin
    rd_word = 16'hFFFF;
    if (txn_cmd == CMD_MEM_RD) begin
      if (txn_lo_en || txn_hi_en) rd_word = mem_q[mem_idx];
    end else if (txn_cmd == CMD_IO_RD && io_hit) begin
      rd_word = io_q[io_sel];
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    ube_d   = ube_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: if (cmd_valid) begin
        addr_d  = bus_address;
        cmd_d   = bus_status;
        ube_d   = bus_upper_byte_enable;
        wdata_d = bus_wdata;
        cnt_d   = 4'(WAIT_STATES);
        state_d = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    readyb_d = (state_d != S_ACK);
    rdata_d  = (state_d == S_ACK && txn_is_read) ? rd_word : rdata_q;
  end

  assign mem_we = (state_q == S_ACK) && (cmd_q == CMD_MEM_WR);
  assign io_we  = (state_q == S_ACK) && (cmd_q == CMD_IO_WR) && io_hit;

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      cmd_q    <= '0;
      ube_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      readyb_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      cmd_q    <= cmd_d;
      ube_q    <= ube_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      readyb_q <= readyb_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) io_q[i] <= '0;
    end else if (io_we) begin
      if (txn_lo_en) io_q[io_sel][7:0]  <= wdata_q[7:0];
      if (txn_hi_en) io_q[io_sel][15:8] <= wdata_q[15:8];
    end
  end

  // NOTE: the RAM has no reset so it maps onto block memory and keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (txn_lo_en) mem_q[mem_idx][7:0]  <= wdata_q[7:0];
      if (txn_hi_en) mem_q[mem_idx][15:8] <= wdata_q[15:8];
    end
  end

  assign bus_rdata = rdata_q;
  assign readyb    = readyb_q;

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: one instance with one wait state, one with none,
// both checked against an address-arithmetic reference model.
module tb_bus_responder;

  localparam int AW     = 10;
  localparam int NWORDS = 1 << AW;
  localparam logic [3:0] MRD  = 4'b1001;
  localparam logic [3:0] MWR  = 4'b1010;
  localparam logic [3:0] IRD  = 4'b0101;
  localparam logic [3:0] IWR  = 4'b0110;
  localparam logic [3:0] IDLE = 4'hF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic [19:0] addr [2];
  logic [3:0]  st   [2];
  logic        ube  [2];
  logic [15:0] wd   [2];
  logic [15:0] rdata0, rdata1;
  logic        rdy0, rdy1;

  bus_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(1)) dut0 (
    .clk(clk), .reset(rst[0]), .bus_address(addr[0]), .bus_status(st[0]),
    .bus_upper_byte_enable(ube[0]), .bus_wdata(wd[0]),
    .bus_rdata(rdata0), .readyb(rdy0));

  bus_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut1 (
    .clk(clk), .reset(rst[1]), .bus_address(addr[1]), .bus_status(st[1]),
    .bus_upper_byte_enable(ube[1]), .bus_wdata(wd[1]),
    .bus_rdata(rdata1), .readyb(rdy1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state per instance
  logic [15:0] mem_m [2][NWORDS];
  logic [15:0] io_m  [2][4];
  logic [15:0] rd_m  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_rdy(input int idx);
    return (idx == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic [15:0] get_rdata(input int idx);
    return (idx == 0) ? rdata0 : rdata1;
  endfunction

  function automatic int ws_of(input int idx);
    return (idx == 0) ? 1 : 0;
  endfunction

  // Applies one transfer to the model; returns the bus_rdata expected at ACK.
  task automatic model_xfer(input int idx, input logic [3:0] s, input logic [19:0] a,
                            input logic u, input logic [15:0] d, output logic [15:0] exp);
    bit lo   = (a % 2) == 0;
    bit hi   = u;
    int w    = (int'(a) / 2) % NWORDS;
    bit io_ok = (int'(a) % 65536) < 8;
    int p    = (int'(a) % 8) / 2;
    case (s)
      MWR: begin
        if (lo) mem_m[idx][w][7:0]  = d[7:0];
        if (hi) mem_m[idx][w][15:8] = d[15:8];
      end
      MRD: rd_m[idx] = (lo || hi) ? mem_m[idx][w] : 16'hFFFF;
      IWR: if (io_ok) begin
        if (lo) io_m[idx][p][7:0]  = d[7:0];
        if (hi) io_m[idx][p][15:8] = d[15:8];
      end
      IRD: rd_m[idx] = io_ok ? io_m[idx][p] : 16'hFFFF;
      default: ;
    endcase
    exp = rd_m[idx];
  endtask

  task automatic xfer(input int idx, input logic [3:0] s, input logic [19:0] a,
                      input logic u, input logic [15:0] d,
                      output logic [15:0] rd, output int ack_cyc);
    logic [15:0] exp;
    int lat;
    bit done;
    @(negedge clk);
    check("ready_idle", get_rdy(idx), 1'b1);
    st[idx] = s; addr[idx] = a; ube[idx] = u; wd[idx] = d;
    @(posedge clk);
    #1;
    // Scramble the bus while the transfer is in flight; the captured copy must win.
    st[idx] = 4'($urandom); addr[idx] = 20'($urandom);
    ube[idx] = 1'($urandom); wd[idx] = 16'($urandom);
    model_xfer(idx, s, a, u, d, exp);
    lat = 0;
    done = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (get_rdy(idx) == 1'b0) done = 1;
    end
    ack_cyc = cyc;
    rd = get_rdata(idx);
    st[idx] = IDLE;
    check("ack_seen", done, 1'b1);
    check("latency", lat, ws_of(idx) + 1);
    check("rdata", rd, exp);
  endtask

  // Starts a mem write on the one-wait-state instance and resets it mid-WAIT or mid-ACK.
  task automatic abort_xfer(input logic [19:0] a, input logic [15:0] d, input bit in_ack);
    @(negedge clk);
    st[0] = MWR; addr[0] = a; ube[0] = 1'b1; wd[0] = d;
    @(posedge clk);
    #1;
    st[0] = IDLE;
    @(negedge clk);
    check("wait_ready", rdy0, 1'b1);
    if (in_ack) begin
      @(negedge clk);
      check("ack_before_reset", rdy0, 1'b0);
    end
    rst[0] = 1'b1;
    #1;
    check("abort_readyb", rdy0, 1'b1);
    check("abort_rdata", rdata0, 16'h0000);
    for (int i = 0; i < 4; i++) io_m[0][i] = '0;
    rd_m[0] = '0;
    @(negedge clk);
    rst[0] = 1'b0;
  endtask

  task automatic rand_op(input int idx);
    logic [3:0]  s;
    logic [19:0] a;
    logic        u;
    logic [15:0] r;
    int          c;
    case ($urandom_range(0, 3))
      0: s = MRD;
      1: s = MWR;
      2: s = IRD;
      default: s = IWR;
    endcase
    if (s == MRD || s == MWR) a = {9'($urandom), 5'd0, 5'($urandom), 1'($urandom)};
    else                      a = {4'($urandom), 11'd0, 5'($urandom)};
    u = 1'($urandom);
    if (s == IRD && a[0] && !u) u = 1'b1;
    xfer(idx, s, a, u, 16'($urandom), r, c);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    int c, c_prev;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; st[i] = IDLE; addr[i] = '0; ube[i] = 1'b0; wd[i] = '0;
      rd_m[i] = '0;
      for (int p = 0; p < 4; p++) io_m[i][p] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_readyb0", rdy0, 1'b1);
    check("reset_rdata0", rdata0, 16'h0000);
    check("reset_readyb1", rdy1, 1'b1);
    check("reset_rdata1", rdata1, 16'h0000);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Word write/read with one wait state
    xfer(0, MWR, 20'h00100, 1'b1, 16'hBEEF, r, c);
    xfer(0, MRD, 20'h00100, 1'b1, 16'h0000, r, c);
    check("beef", r, 16'hBEEF);

    // Byte-lane merge
    xfer(0, MWR, 20'h00200, 1'b1, 16'h0000, r, c);
    xfer(0, MWR, 20'h00201, 1'b1, 16'h12AA, r, c);
    xfer(0, MWR, 20'h00200, 1'b0, 16'hBB34, r, c);
    xfer(0, MRD, 20'h00200, 1'b1, 16'h0000, r, c);
    check("byte_merge", r, 16'h1234);

    // IO decode
    xfer(0, IWR, 20'h00004, 1'b1, 16'hA5A5, r, c);
    xfer(0, IRD, 20'h00004, 1'b1, 16'h0000, r, c);
    check("io_a5a5", r, 16'hA5A5);
    xfer(0, IRD, 20'h00010, 1'b1, 16'h0000, r, c);
    check("io_outside", r, 16'hFFFF);

    // Mirroring and illegal lane code
    xfer(0, MWR, 20'h00000, 1'b1, 16'h0F0F, r, c);
    xfer(0, MRD, 20'h00800, 1'b1, 16'h0000, r, c);
    check("wrap", r, 16'h0F0F);
    xfer(0, MRD, 20'h00001, 1'b0, 16'h0000, r, c);
    check("illegal_rd", r, 16'hFFFF);

    // Reset aborts in WAIT and in ACK
    xfer(0, MWR, 20'h00300, 1'b1, 16'h1357, r, c);
    abort_xfer(20'h00300, 16'h5555, 1'b0);
    xfer(0, MRD, 20'h00300, 1'b1, 16'h0000, r, c);
    check("abort_wait_mem", r, 16'h1357);
    xfer(0, IRD, 20'h00004, 1'b1, 16'h0000, r, c);
    check("abort_io", r, 16'h0000);
    abort_xfer(20'h00300, 16'hAAAA, 1'b1);
    xfer(0, MRD, 20'h00300, 1'b1, 16'h0000, r, c);
    check("abort_ack_mem", r, 16'h1357);

    // Fill the random-test window on both instances
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 32; w++)
        xfer(i, MWR, 20'(w * 2), 1'b1, 16'($urandom), r, c);

    // Zero-wait back-to-back reads: one ACK every other cycle
    xfer(1, MRD, 20'h00000, 1'b1, 16'h0000, r, c_prev);
    for (int i = 1; i < 5; i++) begin
      xfer(1, MRD, 20'(i * 2), 1'b1, 16'h0000, r, c);
      check("b2b_spacing", c - c_prev, 2);
      c_prev = c;
    end

    for (int n = 0; n < 150; n++) begin
      rand_op(0);
      rand_op(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
